// File: rtl/kbd_rx_if.sv
// kbd_rx_if -- host-side bus between the PS/2 keyboard receiver and the
// MMIO read decoder.
//   sig_rd_kb   : pop strobe (host -> receiver), one pulse per byte consumed
//   kb_rdata    : FIFO head byte, show-ahead, 8'h00 when empty
//   kb_ready    : FIFO non-empty
//   kb_overflow : sticky, a good frame was dropped on a full FIFO
//   frame_err   : one-cycle pulse on a rejected or timed-out frame
// Modports: master = host/decoder side, slave = receiver side.

`ifndef KbWidth
`define KbWidth 8
`endif

interface kbd_rx_if;
    logic                 sig_rd_kb;
    logic [`KbWidth-1:0]  kb_rdata;
    logic                 kb_ready;
    logic                 kb_overflow;
    logic                 frame_err;

    modport master (
        output sig_rd_kb,
        input  kb_rdata,
        input  kb_ready,
        input  kb_overflow,
        input  frame_err
    );

    modport slave (
        input  sig_rd_kb,
        output kb_rdata,
        output kb_ready,
        output kb_overflow,
        output frame_err
    );
endinterface

// File: rtl/kbd_rx.sv
// kbd_rx -- PS/2 keyboard frame receiver with a show-ahead byte FIFO.
//   clk, rst_n         : system clock, async active-low reset
//   ps2_clk, ps2_data  : raw PS/2 lines, asynchronous to clk
//   bus (slave)        : sig_rd_kb in; kb_rdata, kb_ready, kb_overflow,
//                        frame_err out (see kbd_rx_if)
// Parameters: FIFO_DEPTH (power of two, >=2), TIMEOUT (idle clk cycles
// before an in-progress frame is abandoned).
// Build option: define KBD_PARITY_CHK_EN to reject frames with bad odd
// parity; otherwise the parity bit is captured and ignored.
//
// state  | meaning
// IDLE   | waiting for a start bit (falling edge with data=0)
// DATA   | shifting 8 data bits, LSB first
// PARITY | capturing the parity bit
// STOP   | checking stop bit (and parity), push or flag error

`ifndef KbWidth
`define KbWidth 8
`endif

module kbd_rx #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] TIMEOUT    = 16'd5000
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     ps2_clk,
    input  logic     ps2_data,
    kbd_rx_if.slave  bus
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // ps2c_sync_q[2] is the extra flop used only for edge detection
    logic [2:0]          ps2c_sync_q, ps2c_sync_d;
    logic [1:0]          ps2d_sync_q, ps2d_sync_d;

    state_t              state_q, state_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [7:0]          shift_q, shift_d;
    logic                par_q, par_d;
    logic [15:0]         tmo_q, tmo_d;
    logic                frame_err_q, frame_err_d;

    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                ovf_q, ovf_d;
    logic [7:0]          mem_q [FIFO_DEPTH];

    logic                fall;
    logic                din;
    logic                par_odd;
    logic                par_ok;
    logic                push;
    logic                pop;
    logic                full;
    logic                do_wr;

    assign ps2c_sync_d = {ps2c_sync_q[1:0], ps2_clk};
    assign ps2d_sync_d = {ps2d_sync_q[0], ps2_data};

    assign fall    = ps2c_sync_q[2] & ~ps2c_sync_q[1];
    assign din     = ps2d_sync_q[1];
    assign par_odd = ^{shift_q, par_q};

`ifdef KBD_PARITY_CHK_EN
    assign par_ok = par_odd;
`else
    assign par_ok = par_odd | 1'b1;
`endif

    // Frame FSM; the timeout is a down-counter reloaded on every edge
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_d       = par_q;
        tmo_d       = tmo_q;
        frame_err_d = 1'b0;
        push        = 1'b0;

        if (state_q == IDLE) begin
            tmo_d = 16'd0;
            if (fall && !din) begin
                state_d   = DATA;
                bit_cnt_d = 3'd0;
                tmo_d     = TIMEOUT;
            end
        end else if (fall) begin
            tmo_d = TIMEOUT;
            case (state_q)
                DATA: begin
                    shift_d   = {din, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    par_d   = din;
                    state_d = STOP;
                end
                default: begin
                    state_d   = IDLE;
                    bit_cnt_d = 3'd0;
                    tmo_d     = 16'd0;
                    if (din && par_ok) begin
                        push = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            endcase
        end else if (tmo_q <= 16'd1) begin
            state_d     = IDLE;
            bit_cnt_d   = 3'd0;
            tmo_d       = 16'd0;
            frame_err_d = 1'b1;
        end else begin
            tmo_d = tmo_q - 16'd1;
        end
    end

    // FIFO: a push on a full FIFO still lands when a pop frees the slot
    // in the same cycle; the write then reuses the slot being popped.
    always_comb begin
        pop      = bus.sig_rd_kb && (count_q != '0);
        full     = (count_q == CNT_W'(FIFO_DEPTH));
        do_wr    = push && (!full || pop);
        ovf_d    = ovf_q | (push && full && !pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(do_wr);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(do_wr) - CNT_W'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps2c_sync_q <= 3'b111;
            ps2d_sync_q <= 2'b11;
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            par_q       <= 1'b0;
            tmo_q       <= 16'd0;
            frame_err_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
        end else begin
            ps2c_sync_q <= ps2c_sync_d;
            ps2d_sync_q <= ps2d_sync_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            tmo_q       <= tmo_d;
            frame_err_q <= frame_err_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    assign bus.kb_ready    = (count_q != '0);
    assign bus.kb_rdata    = (count_q != '0) ? mem_q[rd_ptr_q] : 8'h00;
    assign bus.kb_overflow = ovf_q;
    assign bus.frame_err   = frame_err_q;

endmodule

// File: tb/tb_kbd_rx.sv
// tb_kbd_rx -- directed bench for kbd_rx: PS/2 frames are bit-banged on
// ps2_clk/ps2_data, results are checked on the host bus.

module tb_kbd_rx;

    localparam int          DEPTH = 8;
    localparam logic [15:0] TMO   = 16'd100;
    localparam int          HALF  = 8;

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic ps2_clk  = 1'b1;
    logic ps2_data = 1'b1;

    kbd_rx_if bus();

    kbd_rx #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int err_cnt = 0;
    always @(negedge clk) if (bus.frame_err) err_cnt <= err_cnt + 1;

    int checks    = 0;
    int errors    = 0;
    int last_fall = 0;
    int e0;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    function automatic logic odd_par(input logic [7:0] b);
        return ~^b;
    endfunction

    // One PS/2 bit. With pop_at_fall the pop strobe is placed on the
    // clk edge where the receiver sees this falling edge (2 sync flops
    // plus the edge flop put it three clk edges after the line drops).
    task automatic ps2_bit(input logic b, input bit pop_at_fall);
        @(posedge clk);
        #1 ps2_data = b;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b0;
        last_fall = cyc;
        if (pop_at_fall) begin
            repeat (2) @(posedge clk);
            #1 bus.sig_rd_kb = 1'b1;
            @(posedge clk);
            #1 bus.sig_rd_kb = 1'b0;
            repeat (HALF - 3) @(posedge clk);
        end else begin
            repeat (HALF) @(posedge clk);
        end
        #1 ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par,
                              input logic stop, input bit pop_at_stop);
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], 1'b0);
        ps2_bit(par, 1'b0);
        ps2_bit(stop, pop_at_stop);
        @(posedge clk);
        #1 ps2_data = 1'b1;
        settle(4);
    endtask

    task automatic send_good(input logic [7:0] b);
        send_frame(b, odd_par(b), 1'b1, 1'b0);
    endtask

    task automatic pop_one();
        @(posedge clk);
        #1 bus.sig_rd_kb = 1'b1;
        @(posedge clk);
        #1 bus.sig_rd_kb = 1'b0;
        settle(1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_ready"},  bus.kb_ready,    1'b0);
        check_val({tag, "_rdata"},  bus.kb_rdata,    8'h00);
        check_val({tag, "_ovf"},    bus.kb_overflow, 1'b0);
        check_val({tag, "_ferr"},   bus.frame_err,   1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_q [$];
        int  found;
        int  lat;

        bus.sig_rd_kb = 1'b0;
        settle(3);
        check_reset_outputs("rst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        settle(2);

        // 0x1C with valid odd parity
        e0 = err_cnt;
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        check_val("f1c_ready", bus.kb_ready, 1'b1);
        check_val("f1c_rdata", bus.kb_rdata, 8'h1C);
        check_val("f1c_noerr", err_cnt - e0, 0);
        pop_one();
        check_val("f1c_pop_ready", bus.kb_ready, 1'b0);
        check_val("f1c_pop_rdata", bus.kb_rdata, 8'h00);

        // 0x1C with wrong parity
        e0 = err_cnt;
        send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
`ifdef KBD_PARITY_CHK_EN
        check_val("badpar_err",   err_cnt - e0, 1);
        check_val("badpar_ready", bus.kb_ready, 1'b0);
`else
        check_val("badpar_err",   err_cnt - e0, 0);
        check_val("badpar_ready", bus.kb_ready, 1'b1);
        check_val("badpar_rdata", bus.kb_rdata, 8'h1C);
        pop_one();
`endif

        // bad stop bit
        e0 = err_cnt;
        send_frame(8'h33, odd_par(8'h33), 1'b0, 1'b0);
        check_val("badstop_err",   err_cnt - e0, 1);
        check_val("badstop_ready", bus.kb_ready, 1'b0);

        // lone edge with data=1 in IDLE is ignored
        e0 = err_cnt;
        ps2_bit(1'b1, 1'b0);
        settle(4);
        check_val("idle1_err",   err_cnt - e0, 0);
        check_val("idle1_ready", bus.kb_ready, 1'b0);
        send_good(8'h5A);
        check_val("f5a_rdata", bus.kb_rdata, 8'h5A);
        check_val("f5a_err",   err_cnt - e0, 0);
        pop_one();

        // overflow: nine frames, no pop
        for (int i = 1; i <= 9; i++) send_good(8'(i));
        check_val("ovf_flag",  bus.kb_overflow, 1'b1);
        check_val("ovf_ready", bus.kb_ready,    1'b1);
        for (int i = 1; i <= 8; i++) begin
            check_val($sformatf("ovf_rd%0d", i), bus.kb_rdata, 32'(i));
            pop_one();
        end
        check_val("ovf_empty",  bus.kb_ready,    1'b0);
        check_val("ovf_sticky", bus.kb_overflow, 1'b1);

        @(posedge clk);
        #1 rst_n = 1'b0;
        settle(2);
        check_reset_outputs("rst2");
        @(posedge clk);
        #1 rst_n = 1'b1;
        settle(2);

        // full FIFO, pop coincident with push of 0x55
        for (int i = 0; i < 8; i++) send_good(8'h11 + 8'(i));
        check_val("full_ovf", bus.kb_overflow, 1'b0);
        send_frame(8'h55, odd_par(8'h55), 1'b1, 1'b1);
        check_val("pp_ovf",   bus.kb_overflow, 1'b0);
        check_val("pp_ready", bus.kb_ready,    1'b1);
        exp_q = '{8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h55};
        foreach (exp_q[i]) begin
            check_val($sformatf("pp_rd%0d", i), bus.kb_rdata, exp_q[i]);
            pop_one();
        end
        check_val("pp_empty", bus.kb_ready, 1'b0);

        // timeout after start + 5 data bits
        e0 = err_cnt;
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(1'b1, 1'b0);
        found = 0;
        lat   = 0;
        for (int k = 0; k < int'(TMO) + 20 && found == 0; k++) begin
            @(posedge clk);
            #2;
            if (bus.frame_err) begin
                found = 1;
                lat   = cyc - last_fall;
            end
        end
        check_val("tmo_seen", found, 1);
        // 3 clk edges from the line dropping to the registered edge
        check_val("tmo_latency", lat, int'(TMO) + 3);
        settle(1);
        check_val("tmo_pulse_end", bus.frame_err, 1'b0);
        check_val("tmo_err_once",  err_cnt - e0, 1);
        check_val("tmo_ready",     bus.kb_ready, 1'b0);
        send_good(8'hF0);
        check_val("tmo_f0_ready", bus.kb_ready, 1'b1);
        check_val("tmo_f0_rdata", bus.kb_rdata, 8'hF0);
        check_val("tmo_f0_err",   err_cnt - e0, 1);
        pop_one();

        // reset mid-frame with two bytes queued
        send_good(8'h21);
        send_good(8'h22);
        check_val("mid_queued", bus.kb_ready, 1'b1);
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(i[0], 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        settle(2);
        check_reset_outputs("mid");
        @(posedge clk);
        #1 rst_n = 1'b1;
        settle(2);
        e0 = err_cnt;
        send_good(8'hAA);
        check_val("mid_aa_ready", bus.kb_ready, 1'b1);
        check_val("mid_aa_rdata", bus.kb_rdata, 8'hAA);
        check_val("mid_aa_err",   err_cnt - e0, 0);
        pop_one();
        check_val("mid_aa_only", bus.kb_ready, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/kbd_rx.md
KBD_RX -- requirements
Module: kbd_rx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning received-byte FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter TIMEOUT, default 16'd5000, meaning clk cycles without a PS/2 falling edge before an in-progress frame is abandoned.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on posedge clk.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ps2_clk  input  1  raw PS/2 clock from keyboard, asynchronous to clk.
REQ-006 SHALL have port ps2_data  input  1  raw PS/2 data from keyboard, asynchronous to clk.
REQ-007 SHALL have port sig_rd_kb  input  1  pop strobe from the MMIO read decoder, one pulse per byte consumed.
REQ-008 SHALL have port kb_rdata  output  `KbWidth (8)  FIFO head byte, show-ahead.
REQ-009 SHALL have port kb_ready  output  1  FIFO non-empty.
REQ-010 SHALL have port kb_overflow  output  1  sticky flag: a good frame was dropped because the FIFO was full.
REQ-011 SHALL have port frame_err  output  1  one-cycle pulse on a rejected frame.

Function
REQ-012 SHALL pass ps2_clk and ps2_data through two-flop synchronizers, plus a third ps2_clk flop for edge detection; a falling edge is prev=1, cur=0.
REQ-013 SHALL sample synchronized ps2_data only in cycles with a detected falling edge.
REQ-014 SHALL implement states IDLE, DATA, PARITY, STOP.
REQ-015 IDLE: an edge with data=0 (start bit) SHALL go to DATA with bit count 0; an edge with data=1 SHALL stay in IDLE with no error.
REQ-016 DATA: SHALL shift 8 bits LSB-first and go to PARITY after the 8th bit.
REQ-017 PARITY: SHALL capture the parity bit and go to STOP.
REQ-018 STOP: SHALL accept the frame when stop=1 and parity is valid per REQ-031/032; otherwise SHALL pulse frame_err; SHALL return to IDLE in either case.
REQ-019 An accepted frame SHALL be pushed in the STOP-edge cycle; kb_ready/kb_rdata SHALL reflect it on the next clk cycle.
REQ-020 In any non-IDLE state, TIMEOUT consecutive cycles without an edge SHALL force IDLE, discard the partial byte, and pulse frame_err.
REQ-021 kb_ready SHALL equal FIFO non-empty; kb_rdata SHALL be the entry at the read pointer and 8'h00 when empty.
REQ-022 sig_rd_kb with kb_ready=1 SHALL pop one entry; sig_rd_kb while empty SHALL be ignored.
REQ-023 A push while full with no pop SHALL drop the new byte, set kb_overflow, and leave FIFO contents unchanged.
REQ-024 A push and pop in the same cycle SHALL both take effect, including when full, leaving occupancy unchanged and not setting kb_overflow.
REQ-025 kb_overflow SHALL clear only on reset.
REQ-026 Pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL be tracked with one extra bit so full and empty are distinct.

Reset
REQ-027 While rst_n=0, the block SHALL force state IDLE, bit count 0, timeout counter 0, pointers 0, and occupancy 0.
REQ-028 While rst_n=0, all synchronizer flops SHALL be 1 (bus idle).
REQ-029 While rst_n=0, outputs SHALL be kb_ready=0, kb_rdata=8'h00, kb_overflow=0, frame_err=0.
REQ-030 Reset asserted mid-frame SHALL discard the partial frame; after release, reception SHALL resume at the next start bit.

Configuration
REQ-031 With KBD_PARITY_CHK_EN defined, a frame SHALL be accepted only if the XOR of the 8 data bits and the parity bit is 1 (odd parity).
REQ-032 Without KBD_PARITY_CHK_EN, the parity bit SHALL be captured and ignored; only a bad stop bit or timeout SHALL raise frame_err.

Verification
REQ-033 Frame 0x1C with parity=0 and stop=1 -> kb_ready=1 and kb_rdata=8'h1C one cycle after the stop edge; one sig_rd_kb pulse -> kb_ready=0.
REQ-034 Frame 0x1C with parity=1 -> with KBD_PARITY_CHK_EN: frame_err pulses once and kb_ready stays 0; without it: byte 0x1C is stored.
REQ-035 Nine frames 0x01..0x09 with no pop -> after the 9th frame kb_overflow=1; eight pops return 0x01..0x08, then kb_ready=0.
REQ-036 FIFO full, then a pop in the same cycle as the push of 0x55 -> occupancy stays 8, kb_overflow stays 0, and 0x55 is the last byte read.
REQ-037 Start bit plus 5 data bits then silence -> frame_err pulses exactly TIMEOUT cycles after the last edge; a following 0xF0 frame is received correctly.
REQ-038 rst_n low after the 4th data bit of a frame with 2 bytes queued -> kb_ready=0 and kb_overflow=0; the next full frame 0xAA is received as the only byte.
